// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the strobe-qualified serial link.
// The word size is common to the sender and the receiver.
package serial_link_pkg;

    localparam int SERIAL_WORD_W = 7;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

endpackage

// File: rtl/rx_shift_reg.sv
// Indexed capture register for the serial receiver.
// Each accepted bit is written to the slot chosen by its position within the word.
// Position 0 maps to index 1, so the first bit received lands in word[1].
module rx_shift_reg
    import serial_link_pkg::*;
#(
    parameter int WIDTH = SERIAL_WORD_W,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [CNT_W-1:0] load_pos,
    input  logic             bit_in,
    output logic [1:WIDTH]   word
);

    // Clear on reset or abort; otherwise write bit_in into the addressed slot only
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word <= '0;
        end else if (load) begin
            for (int i = 1; i <= WIDTH; i++) begin
                if (int'(load_pos) == i - 1) begin
                    word[i] <= bit_in;
                end
            end
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// Receiving end of the strobe-qualified serial link.
// Collects WIDTH strobed bits, presents the finished word with a one-cycle
// data_valid pulse and reports a strobe drop mid-word on frame_err.
// Optional feature macro: SERIAL_RX_FRAME_ERR_EN. When it is defined, frame_err
// pulses on an aborted word; when it is undefined, frame_err is tied low.
module serial_receiver
    import serial_link_pkg::*;
#(
    parameter int WIDTH = SERIAL_WORD_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           data_line,
    input  logic           strobe,
    output logic [1:WIDTH] data_out,
    output logic           data_valid,
    output logic           frame_err,
    output logic           busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sr_load;
    logic             sr_clear;
    logic             word_done;
    logic [1:WIDTH]   sr_word;
    logic [1:WIDTH]   full_word;

    rx_shift_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (sr_load),
        .clear    (sr_clear),
        .load_pos (bit_cnt),
        .bit_in   (data_line),
        .word     (sr_word)
    );

    // The last bit has not reached the capture register yet, so splice it in directly
    always_comb begin
        full_word        = sr_word;
        full_word[WIDTH] = data_line;
    end

    // Next-state logic: capture strobed bits, finish on the last one, abort on a strobe drop
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        sr_load    = 1'b0;
        sr_clear   = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                if (strobe) begin
                    sr_load    = 1'b1;
                    cnt_next   = CNT_W'(1);
                    state_next = RECV;
                end
            end
            RECV: begin
                if (strobe) begin
                    sr_load = 1'b1;
                    if (bit_cnt == LAST_CNT) begin
                        word_done  = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = bit_cnt + 1'b1;
                    end
                end else begin
                    sr_clear   = 1'b1;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // State, bit counter and registered word outputs; reset discards any partial word silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_next;
            bit_cnt    <= cnt_next;
            data_valid <= word_done;
            if (word_done) begin
                data_out <= full_word;
            end
        end
    end

`ifdef SERIAL_RX_FRAME_ERR_EN
    logic frame_err_r;

    // Pulse for one cycle after the edge where strobe was seen low mid-word
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= sr_clear;
        end
    end

    assign frame_err = frame_err_r;
`else
    assign frame_err = 1'b0;
`endif

    assign busy = (state == RECV);

endmodule
